// File: rtl/specreg_port_ctrl_pkg.sv
// Shared definitions for the special-register port controller:
// register map, CTRL/STATUS bit positions and the handshake channel states.
package specreg_port_ctrl_pkg;

   localparam int unsigned RegInAddr  = 0;
   localparam int unsigned RegOutAddr = 1;
   localparam int unsigned RegOutData = 2;
   localparam int unsigned RegInData  = 3;
   localparam int unsigned RegCtrl    = 4;
   localparam int unsigned RegStatus  = 5;

   localparam int unsigned CtrlStartIn  = 0;
   localparam int unsigned CtrlStartOut = 1;

   localparam int unsigned StatInBusy    = 0;
   localparam int unsigned StatOutBusy   = 1;
   localparam int unsigned StatInDone    = 2;
   localparam int unsigned StatOutDone   = 3;
   localparam int unsigned StatInTimeout = 4;
   localparam int unsigned StatOutTimeout = 5;
   localparam int unsigned StatOverrun   = 6;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRel
   } chan_state_e;

endpackage

// File: rtl/specreg_hs_chan.sv
// One 4-phase request/acknowledge channel with a request timeout.
// The payload (address, and data for output) is captured on start and held until the next start.
module specreg_hs_chan
   import specreg_port_ctrl_pkg::*;
#(
   parameter int unsigned PW      = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n_i,
   input  logic          start_i,
   input  logic [PW-1:0] payload_i,
   input  logic          ack_i,
   output logic          req_o,
   output logic [PW-1:0] payload_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          timeout_o,
   output logic          overrun_o,
   output logic          capture_o
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam bit TimeoutEn = (TIMEOUT != 0);

   chan_state_e   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] payload_q, payload_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      payload_d = payload_q;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      capture_o = 1'b0;
      overrun_o = start_i && (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d   = StReq;
               payload_d = payload_i;
               cnt_d     = '0;
            end
         end
         StReq: begin
            // Ack takes priority over a timeout expiring on the same edge.
            if (ack_i) begin
               state_d   = StRel;
               capture_o = 1'b1;
            end else if (TimeoutEn && (cnt_q == CntLast)) begin
               state_d   = StIdle;
               timeout_o = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRel: begin
            if (!ack_i) begin
               state_d = StIdle;
               done_o  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         payload_q <= payload_d;
      end
   end

   assign req_o     = (state_q == StReq);
   assign busy_o    = (state_q != StIdle);
   assign payload_o = payload_q;

endmodule

// File: rtl/specreg_port_ctrl.sv
// Special-register block that drives an input and an output port through
// two independent 4-phase handshake channels.
module specreg_port_ctrl
   import specreg_port_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REG  = 16,
   parameter int unsigned PA_WIDTH = 4,
   parameter int unsigned S_WIDTH  = 6,
   parameter int unsigned D_WIDTH  = 34,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst_n_i,
   input  logic                write_enable_i,
   input  logic [S_WIDTH-1:0]  write_reg_i,
   input  logic [D_WIDTH-1:0]  write_data_i,
   input  logic [S_WIDTH-1:0]  read_reg_i,
   output logic [D_WIDTH-1:0]  read_data_o,
   output logic                in_req_o,
   output logic [PA_WIDTH-1:0] in_addr_o,
   input  logic [D_WIDTH-1:0]  in_data_i,
   input  logic                in_ack_i,
   output logic                out_req_o,
   output logic [PA_WIDTH-1:0] out_addr_o,
   output logic [D_WIDTH-1:0]  out_data_o,
   input  logic                out_ack_i
);

   localparam int unsigned IdxW = $clog2(NUM_REG);
   localparam int unsigned OutPW = PA_WIDTH + D_WIDTH;

   logic [D_WIDTH-1:0] regs_q [NUM_REG];
   logic [D_WIDTH-1:0] regs_d [NUM_REG];
   // STATUS bits 6..2 (overrun, out/in timeout, out/in done)
   logic [4:0] sticky_q, sticky_d;

   logic wr_valid, wr_ctrl, wr_status, wr_store;
   logic start_in, start_out;
   logic [IdxW-1:0] widx, ridx;

   logic in_busy, in_done, in_timeout, in_overrun, in_capture;
   logic out_busy, out_done, out_timeout, out_overrun, out_capture;
   logic [OutPW-1:0] out_payload;

   assign widx      = write_reg_i[IdxW-1:0];
   assign ridx      = read_reg_i[IdxW-1:0];
   assign wr_valid  = write_enable_i && (32'(write_reg_i) < NUM_REG);
   assign wr_ctrl   = wr_valid && (write_reg_i == S_WIDTH'(RegCtrl));
   assign wr_status = wr_valid && (write_reg_i == S_WIDTH'(RegStatus));
   assign wr_store  = wr_valid && !wr_ctrl && !wr_status
                      && (write_reg_i != S_WIDTH'(RegInData));
   assign start_in  = wr_ctrl && write_data_i[CtrlStartIn];
   assign start_out = wr_ctrl && write_data_i[CtrlStartOut];

   specreg_hs_chan #(
      .PW      (PA_WIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_in_chan (
      .clk       (clk),
      .rst_n_i   (rst_n_i),
      .start_i   (start_in),
      .payload_i (regs_q[RegInAddr][PA_WIDTH-1:0]),
      .ack_i     (in_ack_i),
      .req_o     (in_req_o),
      .payload_o (in_addr_o),
      .busy_o    (in_busy),
      .done_o    (in_done),
      .timeout_o (in_timeout),
      .overrun_o (in_overrun),
      .capture_o (in_capture)
   );

   specreg_hs_chan #(
      .PW      (OutPW),
      .TIMEOUT (TIMEOUT)
   ) u_out_chan (
      .clk       (clk),
      .rst_n_i   (rst_n_i),
      .start_i   (start_out),
      .payload_i ({regs_q[RegOutAddr][PA_WIDTH-1:0], regs_q[RegOutData]}),
      .ack_i     (out_ack_i),
      .req_o     (out_req_o),
      .payload_o (out_payload),
      .busy_o    (out_busy),
      .done_o    (out_done),
      .timeout_o (out_timeout),
      .overrun_o (out_overrun),
      .capture_o (out_capture)
   );

   assign out_addr_o = out_payload[OutPW-1:D_WIDTH];
   assign out_data_o = out_payload[D_WIDTH-1:0];

   always_comb begin
      regs_d = regs_q;
      if (wr_store) begin
         regs_d[widx] = write_data_i;
      end
      if (in_capture) begin
         regs_d[RegInData] = in_data_i;
      end
   end

   // Clear first, then set, so a new event wins over a same-cycle W1C.
   always_comb begin
      logic [4:0] set_bits, clr_bits;
      set_bits = {in_overrun | out_overrun, out_timeout, in_timeout, out_done, in_done};
      clr_bits = wr_status ? write_data_i[StatOverrun:StatInDone] : 5'b0;
      sticky_d = (sticky_q & ~clr_bits) | set_bits;
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs_q[i] <= '0;
         end
         sticky_q <= '0;
      end else begin
         regs_q   <= regs_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      read_data_o = '0;
      if (32'(read_reg_i) < NUM_REG) begin
         if (read_reg_i == S_WIDTH'(RegStatus)) begin
            read_data_o = D_WIDTH'({sticky_q, out_busy, in_busy});
         end else if (read_reg_i != S_WIDTH'(RegCtrl)) begin
            read_data_o = regs_q[ridx];
         end
      end
   end

   // Output capture strobe is not needed; only the input channel latches data.
   logic unused_out_capture;
   assign unused_out_capture = out_capture;

endmodule

// File: tb/tb_specreg_port_ctrl.sv
// Bench for specreg_port_ctrl: directed handshake scenarios followed by random
// register traffic, all compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_specreg_port_ctrl;

   localparam int NR  = 16;
   localparam int PAW = 4;
   localparam int SW  = 6;
   localparam int DW  = 34;
   localparam int TO  = 4;

   logic          clk;
   logic          rst_n_i;
   logic          write_enable_i;
   logic [SW-1:0] write_reg_i;
   logic [DW-1:0] write_data_i;
   logic [SW-1:0] read_reg_i;
   logic [DW-1:0] read_data_o;
   logic          in_req_o, out_req_o;
   logic [PAW-1:0] in_addr_o, out_addr_o;
   logic [DW-1:0] in_data_i, out_data_o;
   logic          in_ack_i, out_ack_i;

   specreg_port_ctrl #(
      .NUM_REG  (NR),
      .PA_WIDTH (PAW),
      .S_WIDTH  (SW),
      .D_WIDTH  (DW),
      .TIMEOUT  (TO)
   ) dut (
      .clk            (clk),
      .rst_n_i        (rst_n_i),
      .write_enable_i (write_enable_i),
      .write_reg_i    (write_reg_i),
      .write_data_i   (write_data_i),
      .read_reg_i     (read_reg_i),
      .read_data_o    (read_data_o),
      .in_req_o       (in_req_o),
      .in_addr_o      (in_addr_o),
      .in_data_i      (in_data_i),
      .in_ack_i       (in_ack_i),
      .out_req_o      (out_req_o),
      .out_addr_o     (out_addr_o),
      .out_data_o     (out_data_o),
      .out_ack_i      (out_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: channel phase 0 = idle, 1 = requesting, 2 = releasing.
   logic [DW-1:0]  m_mem [NR];
   int             m_st [2];
   int             m_wait [2];
   logic [PAW-1:0] m_addr [2];
   logic [DW-1:0]  m_odata;
   bit             m_done [2];
   bit             m_to [2];
   bit             m_ovr;

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      for (int c = 0; c < 2; c++) begin
         m_st[c] = 0; m_wait[c] = 0; m_addr[c] = '0; m_done[c] = 0; m_to[c] = 0;
      end
      m_odata = '0;
      m_ovr   = 0;
   endfunction

   function automatic void model_step(input bit we, input int wa, input logic [DW-1:0] wd,
                                      input bit iack, input bit oack, input logic [DW-1:0] idata);
      bit start [2];
      bit ack [2];
      bit set_done [2];
      bit set_to [2];
      bit ovr, cap;
      start[0] = we && (wa == 4) && wd[0];
      start[1] = we && (wa == 4) && wd[1];
      ack[0] = iack;
      ack[1] = oack;
      ovr = 0;
      cap = 0;
      for (int c = 0; c < 2; c++) begin
         set_done[c] = 0;
         set_to[c]   = 0;
         if (m_st[c] == 0) begin
            if (start[c]) begin
               m_st[c]   = 1;
               m_wait[c] = 0;
               m_addr[c] = m_mem[c][PAW-1:0];
               if (c == 1) m_odata = m_mem[2];
            end
         end else begin
            if (start[c]) ovr = 1;
            if (m_st[c] == 1) begin
               if (ack[c]) begin
                  m_st[c] = 2;
                  if (c == 0) cap = 1;
               end else begin
                  m_wait[c]++;
                  if (m_wait[c] == TO) begin
                     m_st[c]   = 0;
                     set_to[c] = 1;
                  end
               end
            end else if (!ack[c]) begin
               m_st[c]     = 0;
               set_done[c] = 1;
            end
         end
      end
      if (we && wa < NR && wa != 3 && wa != 4 && wa != 5) m_mem[wa] = wd;
      if (cap) m_mem[3] = idata;
      if (we && wa == 5) begin
         if (wd[2]) m_done[0] = 0;
         if (wd[3]) m_done[1] = 0;
         if (wd[4]) m_to[0] = 0;
         if (wd[5]) m_to[1] = 0;
         if (wd[6]) m_ovr = 0;
      end
      for (int c = 0; c < 2; c++) begin
         if (set_done[c]) m_done[c] = 1;
         if (set_to[c]) m_to[c] = 1;
      end
      if (ovr) m_ovr = 1;
   endfunction

   function automatic logic [DW-1:0] model_read(input int a);
      if (a >= NR || a == 4) return '0;
      if (a == 5) return DW'({m_ovr, m_to[1], m_to[0], m_done[1], m_done[0],
                              m_st[1] != 0, m_st[0] != 0});
      return m_mem[a];
   endfunction

   task automatic rd(input int a, output logic [DW-1:0] d);
      read_reg_i = SW'(a);
      #1;
      d = read_data_o;
   endtask

   task automatic check_all();
      int addrs [3];
      logic [DW-1:0] d;
      check_eq("in_req", 64'(in_req_o), 64'(m_st[0] == 1));
      check_eq("in_addr", 64'(in_addr_o), 64'(m_addr[0]));
      check_eq("out_req", 64'(out_req_o), 64'(m_st[1] == 1));
      check_eq("out_addr", 64'(out_addr_o), 64'(m_addr[1]));
      check_eq("out_data", 64'(out_data_o), 64'(m_odata));
      addrs[0] = 5;
      addrs[1] = 3;
      addrs[2] = int'($urandom_range(0, NR + 3));
      for (int i = 0; i < 3; i++) begin
         rd(addrs[i], d);
         check_eq($sformatf("read[%0d]", addrs[i]), 64'(d), 64'(model_read(addrs[i])));
      end
   endtask

   // Called just after a falling edge; drives inputs, steps the model, checks.
   task automatic tick(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit iack, input bit oack, input logic [DW-1:0] idata);
      write_enable_i = we;
      write_reg_i    = SW'(wa);
      write_data_i   = wd;
      in_ack_i       = iack;
      out_ack_i      = oack;
      in_data_i      = idata;
      @(posedge clk);
      model_step(we, wa, wd, iack, oack, idata);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_tick();
      tick(0, 0, '0, 0, 0, '0);
   endtask

   logic [DW-1:0] rdat;
   logic [63:0]   rnd;
   int            hi_cnt;

   initial begin
      rst_n_i = 1'b0;
      write_enable_i = 0; write_reg_i = '0; write_data_i = '0; read_reg_i = '0;
      in_ack_i = 0; out_ack_i = 0; in_data_i = '0;
      model_reset();
      #12;
      @(negedge clk);
      rst_n_i = 1'b1;
      check_all();

      // Input transfer
      tick(1, 0, 34'h3, 0, 0, '0);
      tick(1, 4, 34'h1, 0, 0, '0);
      check_eq("in_req_after_start", 64'(in_req_o), 64'd1);
      check_eq("in_addr_3", 64'(in_addr_o), 64'h3);
      idle_tick();
      idle_tick();
      tick(0, 0, '0, 1, 0, 34'h2_DEAD_BEEF);
      check_eq("in_req_drop_on_ack", 64'(in_req_o), 64'd0);
      tick(0, 0, '0, 1, 0, '0);
      tick(0, 0, '0, 0, 0, '0);
      rd(3, rdat);
      check_eq("in_data_latched", 64'(rdat), 64'h2_DEAD_BEEF);
      rd(5, rdat);
      check_eq("in_done_status", 64'(rdat), 64'h04);
      tick(1, 5, 34'h7C, 0, 0, '0);

      // Output transfer, OUT_DATA rewritten mid-request
      tick(1, 2, 34'h155, 0, 0, '0);
      tick(1, 4, 34'h2, 0, 0, '0);
      check_eq("out_req_after_start", 64'(out_req_o), 64'd1);
      tick(1, 2, 34'h0, 0, 0, '0);
      check_eq("out_data_held", 64'(out_data_o), 64'h155);
      tick(0, 0, '0, 0, 1, '0);
      check_eq("out_data_at_ack", 64'(out_data_o), 64'h155);
      tick(0, 0, '0, 0, 0, '0);
      rd(5, rdat);
      check_eq("out_done_status", 64'(rdat), 64'h08);
      tick(1, 5, 34'h7C, 0, 0, '0);

      // Timeout: request held exactly TO cycles
      tick(1, 4, 34'h1, 0, 0, 34'h1_1111_1111);
      hi_cnt = int'(in_req_o);
      for (int i = 0; i < 6; i++) begin
         tick(0, 0, '0, 0, 0, 34'h1_1111_1111);
         hi_cnt += int'(in_req_o);
      end
      check_eq("timeout_req_cycles", 64'(hi_cnt), 64'(TO));
      rd(5, rdat);
      check_eq("timeout_status", 64'(rdat), 64'h10);
      rd(3, rdat);
      check_eq("timeout_in_data_kept", 64'(rdat), 64'h2_DEAD_BEEF);
      tick(1, 5, 34'h7C, 0, 0, '0);

      // Overrun: repeated start-in while busy
      tick(1, 4, 34'h1, 0, 0, '0);
      hi_cnt = int'(in_req_o);
      tick(1, 4, 34'h1, 0, 0, '0);
      hi_cnt += int'(in_req_o);
      tick(1, 4, 34'h1, 0, 0, '0);
      hi_cnt += int'(in_req_o);
      tick(0, 0, '0, 1, 0, 34'h0_0000_0ABC);
      hi_cnt += int'(in_req_o);
      tick(0, 0, '0, 0, 0, '0);
      hi_cnt += int'(in_req_o);
      idle_tick();
      hi_cnt += int'(in_req_o);
      check_eq("overrun_single_handshake", 64'(hi_cnt), 64'd3);
      rd(5, rdat);
      check_eq("overrun_status", 64'(rdat), 64'h44);
      tick(1, 5, 34'h40, 0, 0, '0);
      rd(5, rdat);
      check_eq("overrun_w1c", 64'(rdat), 64'h04);
      tick(1, 5, 34'h7C, 0, 0, '0);

      // Concurrent start, then asynchronous reset mid-request
      tick(1, 4, 34'h3, 0, 0, '0);
      check_eq("both_req_in", 64'(in_req_o), 64'd1);
      check_eq("both_req_out", 64'(out_req_o), 64'd1);
      rst_n_i = 1'b0;
      #1;
      check_eq("async_rst_in_req", 64'(in_req_o), 64'd0);
      check_eq("async_rst_out_req", 64'(out_req_o), 64'd0);
      model_reset();
      rd(5, rdat);
      check_eq("async_rst_status", 64'(rdat), 64'h0);
      @(negedge clk);
      rst_n_i = 1'b1;
      check_all();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int sel, wa;
         bit we;
         logic [DW-1:0] wd, idata;
         we  = bit'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 7));
         if (sel < 2) wa = 4;
         else if (sel == 2) wa = 5;
         else wa = int'($urandom_range(0, NR + 3));
         rnd   = {$urandom, $urandom};
         wd    = rnd[DW-1:0];
         rnd   = {$urandom, $urandom};
         idata = rnd[DW-1:0];
         tick(we, wa, wd, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, idata);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/specreg_port_ctrl.md
SPECREG_PORT_CTRL -- requirements
Module: specreg_port_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_REG, 16, number of special registers.
- PA_WIDTH, 4, port address width.
- S_WIDTH, 6, special-register select width.
- D_WIDTH, 34, data width.
- TIMEOUT, 255, cycles a request may wait for ack; 0 disables the timeout.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, the single clock; reset is asynchronous, active-low.
- rst_n_i, in, 1, asynchronous active-low reset.
- write_enable_i, in, 1, special-register write strobe.
- write_reg_i, in, S_WIDTH, write address.
- write_data_i, in, D_WIDTH, write data.
- read_reg_i, in, S_WIDTH, read address.
- read_data_o, out, D_WIDTH, combinational read data.
- in_req_o / out_req_o, out, 1, input/output port requests.
- in_addr_o / out_addr_o, out, PA_WIDTH, port addresses.
- in_data_i, in, D_WIDTH, input port data.
- out_data_o, out, D_WIDTH, output port data.
- in_ack_i / out_ack_i, in, 1, port acknowledges.

Function
REQ-003 Register map SHALL be:
- 0 IN_ADDR (rw).
- 1 OUT_ADDR (rw).
- 2 OUT_DATA (rw).
- 3 IN_DATA (ro).
- 4 CTRL: bit0 start-in, bit1 start-out; reads 0.
- 5 STATUS:
  - bit0 in_busy, bit1 out_busy.
  - bit2 in_done, bit3 out_done.
  - bit4 in_timeout, bit5 out_timeout.
  - bit6 overrun.
  - Bits 2-6 are sticky and write-1-to-clear.
- 6..NUM_REG-1: plain storage.
REQ-004 Writes SHALL take effect at the clk edge where write_enable_i=1; writes to IN_DATA, to read-only bits, or to addresses >=NUM_REG SHALL be ignored.
REQ-005 read_data_o SHALL be combinational from read_reg_i; addresses >=NUM_REG SHALL read 0.
REQ-006 In and out SHALL each have an independent channel FSM: IDLE -> REQ -> REL -> IDLE.
REQ-007 A start bit written while the channel is IDLE SHALL snapshot the address (and, for output, OUT_DATA) and enter REQ. The request output SHALL go high from the following edge.
REQ-008 In REQ, the request SHALL be held high and the address/data held stable. When ack is sampled high, the FSM SHALL go to REL, dropping the request on that edge; the input channel SHALL latch in_data_i into IN_DATA on the same edge.
REQ-009 In REL, when ack is sampled low, the FSM SHALL return to IDLE and set done; the 4-phase handshake is then complete.
REQ-010 In REQ, a counter SHALL count cycles; if it reaches TIMEOUT (TIMEOUT>0) without ack, the FSM SHALL return to IDLE, drop the request and set the timeout bit. IN_DATA SHALL be left unchanged.
REQ-011 A start bit written to a channel not in IDLE SHALL be ignored and SHALL set overrun.
REQ-012 Writing both start bits in one cycle SHALL start both channels concurrently.
REQ-013 If a sticky bit is set and W1C-cleared in the same cycle, the set SHALL win.
REQ-014 Busy SHALL equal (state != IDLE).
REQ-015 Changing IN_ADDR, OUT_ADDR or OUT_DATA during a transfer SHALL NOT alter the port outputs until the next start.

Reset
REQ-016 rst_n_i low SHALL, asynchronously:
- force both FSMs to IDLE;
- drive in_req_o and out_req_o to 0;
- drive in_addr_o, out_addr_o and out_data_o to 0;
- clear all registers, STATUS and counters.
REQ-017 Reset asserted mid-handshake SHALL drop the request immediately, with no done or timeout flag.

Structure
REQ-018 A shared package SHALL hold:
- register-address constants;
- STATUS/CTRL bit-index constants;
- the channel state enum.
REQ-019 Each channel FSM plus its timeout counter SHALL be one sub-module, specreg_hs_chan, instantiated twice.

Verification
REQ-020 Input transfer:
- Stimulus: IN_ADDR=0x3; start-in; ack after 3 cycles with in_data_i=0x2_DEAD_BEEF; ack low 2 cycles later.
- Response: in_req_o high 1 cycle after the start; in_addr_o=0x3; IN_DATA=0x2_DEAD_BEEF; in_done=1; in_busy=0.
REQ-021 Output transfer:
- Stimulus: OUT_DATA=0x155; start-out; write OUT_DATA=0 mid-REQ.
- Response: out_data_o stays 0x155 until ack.
REQ-022 Timeout:
- Stimulus: TIMEOUT=4; start-in; no ack.
- Response: in_req_o drops after 4 cycles in REQ; in_timeout=1; IN_DATA unchanged.
REQ-023 Overrun:
- Stimulus: start-in twice while busy.
- Response: overrun=1; one handshake only.
- Follow-up: write STATUS=0x40; overrun clears.
REQ-024 Reset and concurrency:
- rst_n_i low during REQ: in_req_o=0 without waiting for a clock edge; STATUS reads 0.
- Simultaneous start-in and start-out: both requests high in the same cycle.
